// File: rtl/sixteen_row_feeder.sv
// sixteen_row_feeder: packs a serial element stream into no_of_units-wide rows,
// launches each row into the reduction organizer with a one-cycle strobe, waits
// for the per-row acknowledge, and holds the organizer start level for the whole
// vector until the final-adder completion arrives.
// Optional build macro SIXTEEN_ROW_FEEDER_PAD_EN adds an elem_last input that
// ends the vector early with a zero-padded final row.
module sixteen_row_feeder #(
    parameter int element_width   = 32,
    parameter int no_of_units     = 16,
    parameter int row_count_width = 8
) (
    input  logic                                 clk,
    input  logic                                 main_reset_n,
    input  logic                                 op_start,
    input  logic [row_count_width-1:0]           no_of_rows,
    input  logic [element_width-1:0]             elem_in,
    input  logic                                 elem_valid,
`ifdef SIXTEEN_ROW_FEEDER_PAD_EN
    input  logic                                 elem_last,
`endif
    output logic                                 elem_ready,
    output logic [no_of_units*element_width-1:0] row_out,
    output logic                                 row_strobe,
    input  logic                                 row_ack,
    output logic                                 start_out,
    input  logic                                 result_done,
    output logic                                 busy,
    output logic                                 done
);

    localparam int LANE_W = $clog2(no_of_units);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(no_of_units - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ISSUE,
        WAIT_ACK,
        DRAIN,
        FIN
    } state_t;

    state_t                                state_q, state_d;
    logic [LANE_W-1:0]                     lane_q, lane_d;
    logic [row_count_width-1:0]            rows_q, rows_d;
    logic [row_count_width-1:0]            nrows_q, nrows_d;
    logic [no_of_units*element_width-1:0]  row_q, row_d;
    logic                                  last_q, last_d;
    logic                                  elem_ready_q, elem_ready_d;
    logic                                  row_strobe_q, row_strobe_d;
    logic                                  start_out_q, start_out_d;
    logic                                  busy_q, busy_d;
    logic                                  done_q, done_d;
    logic                                  elem_last_i;

`ifdef SIXTEEN_ROW_FEEDER_PAD_EN
    assign elem_last_i = elem_last;
`else
    assign elem_last_i = 1'b0;
`endif

    // Next-state, datapath and registered-output decode for the feeder FSM.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        rows_d  = rows_q;
        nrows_d = nrows_q;
        row_d   = row_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (op_start) begin
                    if (no_of_rows != '0) begin
                        nrows_d = no_of_rows;
                        lane_d  = '0;
                        rows_d  = '0;
                        last_d  = 1'b0;
                        state_d = FILL;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FILL: begin
                // elem_ready_q is high throughout FILL, so this is the handshake.
                if (elem_valid && elem_ready_q) begin
                    for (int k = 0; k < no_of_units; k++) begin
                        if (LANE_W'(k) == lane_q)
                            row_d[k*element_width +: element_width] = elem_in;
                        else if (elem_last_i && (LANE_W'(k) > lane_q))
                            row_d[k*element_width +: element_width] = '0;
                    end
                    if ((lane_q == LAST_LANE) || elem_last_i) begin
                        lane_d  = '0;
                        rows_d  = row_count_width'(rows_q + 1'b1);
                        last_d  = elem_last_i;
                        state_d = ISSUE;
                    end else begin
                        lane_d = LANE_W'(lane_q + 1'b1);
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (row_ack) begin
                    if ((rows_q == nrows_q) || last_q)
                        state_d = DRAIN;
                    else
                        state_d = FILL;
                end
            end
            DRAIN: begin
                if (result_done)
                    state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are glitch-free flops.
        elem_ready_d = (state_d == FILL);
        row_strobe_d = (state_d == ISSUE);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == FIN);
        start_out_d  = (state_d == FILL) || (state_d == ISSUE) ||
                       (state_d == WAIT_ACK) || (state_d == DRAIN);
    end

    // State, datapath and output registers; reset abandons any vector in flight.
    always_ff @(posedge clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            rows_q       <= '0;
            nrows_q      <= '0;
            row_q        <= '0;
            last_q       <= 1'b0;
            elem_ready_q <= 1'b0;
            row_strobe_q <= 1'b0;
            start_out_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            rows_q       <= rows_d;
            nrows_q      <= nrows_d;
            row_q        <= row_d;
            last_q       <= last_d;
            elem_ready_q <= elem_ready_d;
            row_strobe_q <= row_strobe_d;
            start_out_q  <= start_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign elem_ready = elem_ready_q;
    assign row_out    = row_q;
    assign row_strobe = row_strobe_q;
    assign start_out  = start_out_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sixteen_row_feeder.sv
// Bench for sixteen_row_feeder: expected rows are queued as elements are issued;
// a negedge monitor pops and compares on every row_strobe. An ack responder
// returns row_ack five cycles after each strobe.
module tb_sixteen_row_feeder;

    localparam int EW = 32;
    localparam int NU = 16;
    localparam int RW = 8;

    logic              clk;
    logic              main_reset_n;
    logic              op_start;
    logic [RW-1:0]     no_of_rows;
    logic [EW-1:0]     elem_in;
    logic              elem_valid;
`ifdef SIXTEEN_ROW_FEEDER_PAD_EN
    logic              elem_last;
`endif
    logic              elem_ready;
    logic [NU*EW-1:0]  row_out;
    logic              row_strobe;
    logic              row_ack;
    logic              start_out;
    logic              result_done;
    logic              busy;
    logic              done;

    int checks;
    int errors;
    int strobe_cnt;
    int done_cnt;
    int ack_cnt;
    int ack_cd;
    logic spur_ack;
    logic [NU*EW-1:0] exp_q[$];

    sixteen_row_feeder #(
        .element_width(EW),
        .no_of_units(NU),
        .row_count_width(RW)
    ) dut (
        .clk(clk),
        .main_reset_n(main_reset_n),
        .op_start(op_start),
        .no_of_rows(no_of_rows),
        .elem_in(elem_in),
        .elem_valid(elem_valid),
`ifdef SIXTEEN_ROW_FEEDER_PAD_EN
        .elem_last(elem_last),
`endif
        .elem_ready(elem_ready),
        .row_out(row_out),
        .row_strobe(row_strobe),
        .row_ack(row_ack),
        .start_out(start_out),
        .result_done(result_done),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Scoreboard monitor: compare each presented row against the oldest expectation.
    always @(negedge clk) begin
        if (main_reset_n && done) done_cnt++;
        if (main_reset_n && row_strobe) begin
            strobe_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL row_unexpected actual=%0h required=none", row_out[EW-1:0]);
            end else begin
                logic [NU*EW-1:0] e;
                e = exp_q.pop_front();
                if (row_out !== e) begin
                    errors++;
                    $display("FAIL row actual_lane0=%0h lane4=%0h required_lane0=%0h lane4=%0h",
                             row_out[EW-1:0], row_out[4*EW +: EW], e[EW-1:0], e[4*EW +: EW]);
                end else begin
                    $display("ok   row lane0=%0h lane15=%0h", row_out[EW-1:0], row_out[15*EW +: EW]);
                end
            end
        end
    end

    // Ack responder: row_ack five cycles after each strobe; elem_ready must stay low meanwhile.
    initial begin
        row_ack = 1'b0;
        ack_cd  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!main_reset_n) ack_cd = 0;
            else if (row_strobe) ack_cd = 5;
            else if (ack_cd > 0) ack_cd--;
            row_ack = (ack_cd == 1) || spur_ack;
            if (ack_cd == 1) ack_cnt++;
            if (ack_cd > 0 && main_reset_n) begin
                checks++;
                if (elem_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_while_wait_ack actual=%0b required=0", elem_ready);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input int base, input int nvalid);
        logic [NU*EW-1:0] r;
        r = '0;
        for (int k = 0; k < NU; k++)
            if (k < nvalid) r[k*EW +: EW] = EW'(base + k);
        exp_q.push_back(r);
    endtask

    task automatic start_op(input int n);
        op_start   = 1'b1;
        no_of_rows = RW'(n);
        tick();
        op_start   = 1'b0;
    endtask

    task automatic send(input int v, input logic last);
        int t;
        elem_in    = EW'(v);
        elem_valid = 1'b1;
`ifdef SIXTEEN_ROW_FEEDER_PAD_EN
        elem_last  = last;
`else
        if (last) $display("note: elem_last not available in this build");
`endif
        t = 0;
        while (!elem_ready && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=%0d required=<200", t);
        end
        tick();
        elem_valid = 1'b0;
`ifdef SIXTEEN_ROW_FEEDER_PAD_EN
        elem_last  = 1'b0;
`endif
    endtask

    // Wait for the row acks, answer with result_done, then wait for done.
    task automatic finish_vector(input int ack_target, input int done_target);
        int t;
        t = 0;
        while (ack_cnt < ack_target && t < 300) begin
            tick();
            t++;
        end
        check("ack_reached", 64'(ack_cnt), 64'(ack_target));
        tick(); tick(); tick();
        check("start_in_drain", 64'(start_out), 64'd1);
        result_done = 1'b1;
        tick();
        result_done = 1'b0;
        t = 0;
        while (done_cnt < done_target && t < 20) begin
            tick();
            t++;
        end
        check("done_count", 64'(done_cnt), 64'(done_target));
        tick();
        check("busy_after", 64'(busy), 64'd0);
        check("start_after", 64'(start_out), 64'd0);
    endtask

    initial begin
        int s0;
        int d0;
        checks = 0; errors = 0; strobe_cnt = 0; done_cnt = 0; ack_cnt = 0;
        spur_ack = 1'b0;
        main_reset_n = 1'b0;
        op_start = 1'b0; no_of_rows = '0; elem_in = '0; elem_valid = 1'b0; result_done = 1'b0;
`ifdef SIXTEEN_ROW_FEEDER_PAD_EN
        elem_last = 1'b0;
`endif
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(elem_ready), 64'd0);
        check("rst_start", 64'(start_out), 64'd0);
        check("rst_row", 64'(row_out[63:0]), 64'd0);
        main_reset_n = 1'b1;
        tick();

        // Basic vector: one row of 1..16.
        s0 = strobe_cnt;
        start_op(1);
        check("basic_start_level", 64'(start_out), 64'd1);
        check("basic_ready", 64'(elem_ready), 64'd1);
        push_row(1, 16);
        for (int i = 1; i <= 16; i++) send(i, 1'b0);
        finish_vector(1, 1);
        check("basic_strobes", 64'(strobe_cnt - s0), 64'd1);

        // Three rows with elem_valid toggling every other cycle.
        s0 = strobe_cnt;
        start_op(3);
        push_row(1, 16); push_row(17, 16); push_row(33, 16);
        for (int i = 1; i <= 48; i++) begin
            send(i, 1'b0);
            tick();
        end
        finish_vector(4, 2);
        check("multi_strobes", 64'(strobe_cnt - s0), 64'd3);

        // Zero-length vector: straight to FIN, start_out never rises.
        s0 = strobe_cnt;
        d0 = done_cnt;
        start_op(0);
        check("zero_start", 64'(start_out), 64'd0);
        check("zero_done_now", 64'(done), 64'd1);
        tick();
        check("zero_start2", 64'(start_out), 64'd0);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("zero_strobes", 64'(strobe_cnt - s0), 64'd0);

        // Ignored events during FILL.
        s0 = strobe_cnt;
        d0 = done_cnt;
        start_op(1);
        push_row(201, 16);
        for (int i = 0; i < 5; i++) send(201 + i, 1'b0);
        spur_ack = 1'b1; result_done = 1'b1; op_start = 1'b1; no_of_rows = 8'd7;
        tick();
        spur_ack = 1'b0; result_done = 1'b0; op_start = 1'b0;
        tick();
        check("ign_ready", 64'(elem_ready), 64'd1);
        check("ign_busy", 64'(busy), 64'd1);
        check("ign_strobes", 64'(strobe_cnt - s0), 64'd0);
        for (int i = 5; i < 16; i++) send(201 + i, 1'b0);
        finish_vector(5, d0 + 1);
        check("ign_strobes_end", 64'(strobe_cnt - s0), 64'd1);

        // Reset after lane 7 of row 2.
        d0 = done_cnt;
        start_op(3);
        push_row(301, 16);
        for (int i = 0; i < 24; i++) send(301 + i, 1'b0);
        main_reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_start", 64'(start_out), 64'd0);
        check("mid_rst_ready", 64'(elem_ready), 64'd0);
        check("mid_rst_row", 64'(row_out[63:0]), 64'd0);
        check("mid_rst_strobe", 64'(row_strobe | done), 64'd0);
        tick(); tick();
        main_reset_n = 1'b1;
        tick();
        check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        exp_q.delete();
        ack_cnt = 6;
        push_row(401, 16);
        start_op(1);
        for (int i = 0; i < 16; i++) send(401 + i, 1'b0);
        finish_vector(7, d0 + 1);

        // Early-terminated vector with elem_last on the 20th element.
        s0 = strobe_cnt;
        d0 = done_cnt;
        start_op(4);
`ifdef SIXTEEN_ROW_FEEDER_PAD_EN
        push_row(1, 16); push_row(17, 4);
        for (int i = 1; i <= 20; i++) send(i, (i == 20));
        finish_vector(9, d0 + 1);
        check("pad_strobes", 64'(strobe_cnt - s0), 64'd2);
`else
        push_row(1, 16);
        for (int i = 1; i <= 20; i++) send(i, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("nopad_strobes", 64'(strobe_cnt - s0), 64'd1);
        check("nopad_in_fill", 64'(elem_ready), 64'd1);
        check("nopad_busy", 64'(busy), 64'd1);
        check("nopad_no_done", 64'(done_cnt - d0), 64'd0);
        main_reset_n = 1'b0;
        tick();
        main_reset_n = 1'b1;
        tick();
`endif
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
